// File: rtl/pshare_if.sv
// Predict/update/statistics signal bundle for the pshare branch predictor.
// The master side is fetch/retire logic; the slave side is the predictor.
interface pshare_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
);
   logic              pred_valid;
   logic [ADDR_W-1:0] pred_pc;
   logic              pred_out_valid;
   logic              pred_taken;
   logic              pred_hit;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_taken;
   logic [ADDR_W-1:0] upd_target;
   logic [CNT_W-1:0]  branch_count;
   logic [CNT_W-1:0]  mispredict_count;

   modport master (
      output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
      input  pred_out_valid, pred_taken, pred_hit, pred_target,
             branch_count, mispredict_count
   );

   modport slave (
      input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
      output pred_out_valid, pred_taken, pred_hit, pred_target,
             branch_count, mispredict_count
   );
endinterface

// File: rtl/pshare_predictor.sv
// Per-address (pshare) branch predictor: local history per BHT entry, 2-bit PHT indexed by hist^pc.
// Define PSHARE_STATS_EN to build the saturating branch/mispredict counters; otherwise they read 0.
module pshare_predictor #(
   parameter int ADDR_W   = 32,
   parameter int BHT_BITS = 6,
   parameter int HIST_W   = 6,
   parameter int CNT_W    = 32
) (
   input  logic     clk,
   input  logic     reset,
   pshare_if.slave  bus
);
   localparam int BHT_N = 1 << BHT_BITS;
   localparam int PHT_N = 1 << HIST_W;

   logic [HIST_W-1:0] hist_q [BHT_N];
   logic [HIST_W-1:0] hist_d [BHT_N];
   logic [1:0]        pht_q  [PHT_N];
   logic [1:0]        pht_d  [PHT_N];
   logic [ADDR_W-1:0] tgt_q  [BHT_N];
   logic [ADDR_W-1:0] tgt_d  [BHT_N];
   logic              tv_q   [BHT_N];
   logic              tv_d   [BHT_N];

   logic              out_valid_q, out_valid_d;
   logic              taken_q, taken_d;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] target_q, target_d;

   logic [BHT_BITS-1:0] bi_p, bi_u;
   logic [HIST_W-1:0]   pi_p, pi_u;
   logic [1:0]          upd_old;

   function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      else    return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   // Only the word-aligned index bits of each PC participate; no tags.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.pred_pc, bus.upd_pc};

   always_comb begin
      bi_p     = bus.pred_pc[BHT_BITS+1:2];
      pi_p     = hist_q[bi_p] ^ bus.pred_pc[HIST_W+1:2];
      bi_u     = bus.upd_pc[BHT_BITS+1:2];
      pi_u     = hist_q[bi_u] ^ bus.upd_pc[HIST_W+1:2];
      upd_old  = pht_q[pi_u];

      hist_d   = hist_q;
      pht_d    = pht_q;
      tgt_d    = tgt_q;
      tv_d     = tv_q;

      out_valid_d = bus.pred_valid;
      taken_d     = taken_q;
      hit_d       = hit_q;
      target_d    = target_q;

      // Lookup reads the _q tables, so a same-cycle update is not visible to it.
      if (bus.pred_valid) begin
         taken_d  = pht_q[pi_p][1];
         hit_d    = tv_q[bi_p];
         target_d = tv_q[bi_p] ? tgt_q[bi_p] : '0;
      end

      if (bus.upd_valid) begin
         pht_d[pi_u]  = sat_cnt(upd_old, bus.upd_taken);
         hist_d[bi_u] = {hist_q[bi_u][HIST_W-2:0], bus.upd_taken};
         if (bus.upd_taken) begin
            tgt_d[bi_u] = bus.upd_target;
            tv_d[bi_u]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q      <= '{default: '0};
         pht_q       <= '{default: 2'b01};
         tgt_q       <= '{default: '0};
         tv_q        <= '{default: 1'b0};
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         hit_q       <= 1'b0;
         target_q    <= '0;
      end else begin
         hist_q      <= hist_d;
         pht_q       <= pht_d;
         tgt_q       <= tgt_d;
         tv_q        <= tv_d;
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         hit_q       <= hit_d;
         target_q    <= target_d;
      end
   end

   assign bus.pred_out_valid = out_valid_q;
   assign bus.pred_taken     = taken_q;
   assign bus.pred_hit       = hit_q;
   assign bus.pred_target    = target_q;

`ifdef PSHARE_STATS_EN
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic             mispredict;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      mispredict    = bus.upd_valid && (upd_old[1] != bus.upd_taken);
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (bus.upd_valid) branch_cnt_d  = sat_inc(branch_cnt_q);
      if (mispredict)    mispred_cnt_d = sat_inc(mispred_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus.branch_count     = branch_cnt_q;
   assign bus.mispredict_count = mispred_cnt_q;
`else
   assign bus.branch_count     = '0;
   assign bus.mispredict_count = '0;
`endif
endmodule
